noc_eject_port: RTL

- Client-side ejection endpoint. It sinks flits from a t_switch_top tx port (the down direction of a noc_if link).
- Buffers flits in per-VC FIFOs and returns per-VC credits to the switch.
- Presents a single valid/ready stream to the client logic.
- Counterpart to the switch's credit-based transmitter; replaces verif_client's receive side in synthesizable designs.

---
 rtl/noc_eject_port.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/noc_eject_port.sv
// Ejection endpoint: per-VC FIFOs, round-robin registered output stage, credits returned on client pop.
// Optional NOC_EJECT_DEST_CHECK_EN adds the sticky err_misroute destination check against posx.
module noc_eject_port #(
    parameter int N             = 4,
    parameter int A_W           = 3,
    parameter int D_W           = 8,
    parameter int VC_W          = 4,
    parameter int VC_FIFO_DEPTH = 4,
    parameter int posx          = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [VC_W-1:0]            rx_vc_target,
    input  logic [A_W+D_W-1:0]         rx_packet,
    output logic [VC_W-1:0]            rx_vc_credit_gnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_W+D_W-1:0]         out_packet,
    output logic [$clog2(VC_W)-1:0]    out_vc,
    output logic [31:0]                rx_count,
    output logic                       err_overflow,
    output logic                       err_onehot
`ifdef NOC_EJECT_DEST_CHECK_EN
    ,
    output logic                       err_misroute
`endif
);

    localparam int PW    = A_W + D_W;
    localparam int VI_W  = $clog2(VC_W);
    localparam int PTR_W = $clog2(VC_FIFO_DEPTH);
    localparam int CNT_W = $clog2(VC_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(VC_FIFO_DEPTH - 1);

    // Handshake: a flit moves to the client on any cycle where out_valid && out_ready;
    // out_valid/out_packet/out_vc never change while out_valid && !out_ready.
    typedef enum logic {VC_EMPTY = 1'b0, VC_HOLDING = 1'b1} vc_state_t;

    vc_state_t        vc_state     [VC_W];
    vc_state_t        vc_state_nxt [VC_W];
    logic [PW-1:0]    mem          [VC_W][VC_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr       [VC_W];
    logic [PTR_W-1:0] rd_ptr       [VC_W];
    logic [CNT_W-1:0] cnt          [VC_W];
    logic [VI_W-1:0]  rr_ptr;

    logic             tgt_onehot;
    logic             tgt_multi;
    logic             pop;
    logic [VC_W-1:0]  full_vec;
    logic [VC_W-1:0]  wr_vec;
    logic [VC_W-1:0]  pop_vec;
    logic [VC_W-1:0]  avail_vec;
    logic             arb_found;
    logic [VI_W-1:0]  arb_vc;
    logic [VI_W-1:0]  arb_start;
    logic [PTR_W-1:0] arb_rd;
    logic [PW-1:0]    arb_pkt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(VC_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [VI_W-1:0] vc_inc(input logic [VI_W-1:0] v);
        return (v == VI_W'(VC_W - 1)) ? '0 : v + 1'b1;
    endfunction

    assign tgt_onehot = $onehot(rx_vc_target);
    assign tgt_multi  = !$onehot0(rx_vc_target);
    assign pop        = out_valid && out_ready;

    // Full check uses occupancy before any same-cycle pop.
    always_comb begin
        full_vec  = '0;
        wr_vec    = '0;
        pop_vec   = '0;
        avail_vec = '0;
        for (int v = 0; v < VC_W; v++) begin
            full_vec[v]  = (cnt[v] >= FULL_CNT);
            wr_vec[v]    = tgt_onehot && rx_vc_target[v] && !full_vec[v];
            pop_vec[v]   = pop && (out_vc == VI_W'(v));
            avail_vec[v] = (vc_state[v] == VC_HOLDING) && !(pop_vec[v] && cnt[v] == CNT_W'(1));
        end
    end

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            vc_state_nxt[v] = vc_state[v];
            unique case (vc_state[v])
                VC_EMPTY:   if (wr_vec[v]) vc_state_nxt[v] = VC_HOLDING;
                VC_HOLDING: if (pop_vec[v] && !wr_vec[v] && cnt[v] == CNT_W'(1))
                                vc_state_nxt[v] = VC_EMPTY;
            endcase
        end
    end

    // The popped entry is still counted in its FIFO, so a same-VC refill reads the entry behind it.
    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_vc    = '0;
        arb_start = pop ? vc_inc(out_vc) : rr_ptr;
        for (int i = 0; i < VC_W; i++) begin
            idx = (int'(arb_start) + i) % VC_W;
            if (!arb_found && avail_vec[idx]) begin
                arb_found = 1'b1;
                arb_vc    = VI_W'(idx);
            end
        end
        arb_rd  = pop_vec[arb_vc] ? ptr_inc(rd_ptr[arb_vc]) : rd_ptr[arb_vc];
        arb_pkt = mem[arb_vc][arb_rd];
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_W; v++) begin
            if (wr_vec[v]) mem[v][wr_ptr[v]] <= rx_packet;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_W; v++) begin
                vc_state[v] <= VC_EMPTY;
                wr_ptr[v]   <= '0;
                rd_ptr[v]   <= '0;
                cnt[v]      <= '0;
            end
            rr_ptr           <= '0;
            out_valid        <= 1'b0;
            out_packet       <= '0;
            out_vc           <= '0;
            rx_vc_credit_gnt <= '0;
            rx_count         <= '0;
            err_overflow     <= 1'b0;
            err_onehot       <= 1'b0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                vc_state[v] <= vc_state_nxt[v];
                if (wr_vec[v])  wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop_vec[v]) rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                cnt[v] <= cnt[v] + CNT_W'(wr_vec[v]) - CNT_W'(pop_vec[v]);
            end
            rx_vc_credit_gnt <= pop_vec;
            if (pop) rr_ptr <= vc_inc(out_vc);
            if (!out_valid || pop) begin
                out_valid <= arb_found;
                if (arb_found) begin
                    out_packet <= arb_pkt;
                    out_vc     <= arb_vc;
                end
            end
            if (|wr_vec) rx_count <= rx_count + 32'd1;
            if (tgt_onehot && |(rx_vc_target & full_vec)) err_overflow <= 1'b1;
            if (tgt_multi) err_onehot <= 1'b1;
        end
    end

`ifdef NOC_EJECT_DEST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misroute <= 1'b0;
        end else if (|wr_vec && (rx_packet[PW-1 -: A_W] != A_W'(posx))) begin
            err_misroute <= 1'b1;
        end
    end
`endif

endmodule
